// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional message lock: define UART_ARB_LOCK_EN.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GUARD,
        WAIT
    } arb_state_t;

    localparam logic [7:0] EOM_DEFAULT = 8'h0A;
    localparam int         GCW         = 4;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: search starts one past `last`.
// Returns the one-hot winner, its index and whether any request was seen.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            found
);

    logic [IW-1:0] j;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = IW'((int'(last) + k) % NREQ);
            if (!found && req[j]) begin
                found   = 1'b1;
                win[j]  = 1'b1;
                win_idx = j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART strobe port among NREQ byte producers.
// Define UART_ARB_LOCK_EN to hold the port for a requester until it sends EOM.
module uart_tx_arbiter #(
    parameter int         NREQ  = 4,
    parameter int         GUARD = 2,
    parameter logic [7:0] EOM   = uart_arb_pkg::EOM_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        txdata,
    output logic              txclk,
    input  logic              txready,
    output logic              busy
);

    import uart_arb_pkg::*;

    localparam int IW = $clog2(NREQ);

    arb_state_t      state;
    arb_state_t      state_n;
    logic [GCW-1:0]  cnt;
    logic [IW-1:0]   last;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] req_eff;
    logic [NREQ-1:0] win;
    logic            found;
    logic            accept;
    logic [7:0]      sel_byte;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req_eff),
        .last    (last),
        .win     (win),
        .win_idx (win_idx),
        .found   (found)
    );

    assign sel_byte = req_data[{win_idx, 3'b000} +: 8];
    assign txclk    = (state == STROBE);
    assign busy     = (state != IDLE);

`ifdef UART_ARB_LOCK_EN
    logic          locked;
    logic [IW-1:0] lock_idx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (accept) begin
            locked   <= (sel_byte != EOM);
            lock_idx <= win_idx;
        end
    end

    // While locked only the owner is visible to the picker.
    always_comb begin
        req_eff = req_valid;
        if (locked) begin
            req_eff           = '0;
            req_eff[lock_idx] = req_valid[lock_idx];
        end
    end
`else
    logic unused_eom;

    assign req_eff    = req_valid;
    assign unused_eom = (sel_byte == EOM);
`endif

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        req_ready = '0;
        unique case (state)
            IDLE: begin
                if (reset_n && txready && found) begin
                    accept    = 1'b1;
                    req_ready = win;
                    state_n   = STROBE;
                end
            end
            STROBE: state_n = uart_arb_pkg::GUARD;
            uart_arb_pkg::GUARD: begin
                if (cnt <= GCW'(1)) state_n = WAIT;
            end
            WAIT: begin
                if (txready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            txdata <= '0;
            grant  <= '0;
            last   <= IW'(NREQ - 1);
        end else begin
            state <= state_n;
            if (accept) begin
                txdata <= sel_byte;
                grant  <= win;
                last   <= win_idx;
            end else if (state == WAIT && txready) begin
                grant <= '0;
            end
            // txready is blind for GUARD cycles after each strobe
            if (state == STROBE) begin
                cnt <= GCW'(GUARD);
            end else if (state == uart_arb_pkg::GUARD) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a transaction-age model.
// Follows UART_ARB_LOCK_EN when it is defined for the build.
module tb_uart_tx_arbiter;

    localparam int         NREQ  = 4;
    localparam int         GUARD = 2;
    localparam logic [7:0] EOM   = 8'h0A;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic [7:0]  txdata;
    logic        txclk;
    logic        txready;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ  (NREQ),
        .GUARD (GUARD),
        .EOM   (EOM)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant     (grant),
        .txdata    (txdata),
        .txclk     (txclk),
        .txready   (txready),
        .busy      (busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: a byte in flight is described by its age in cycles since accept.
    bit         m_active;
    int         m_age;
    int         m_w;
    int         m_last;
    logic [7:0] m_txdata;
    bit         m_locked;
    int         m_lock_w;
    bit         chk_en;

    logic [3:0] last_rdy;
    logic       last_busy;
    int         last_cyc;
    logic [7:0] slog[$];
    int         scyc[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] cand, input int last);
        int r;
        int j;
        r = -1;
        for (int k = 1; k <= NREQ; k++) begin
            j = (last + k) % NREQ;
            if (r < 0 && ((cand >> j) & 4'd1) != 4'd0) r = j;
        end
        return r;
    endfunction

    task automatic step(input logic rn, input logic [3:0] v,
                        input logic [31:0] d, input logic tr);
        logic [3:0] cand;
        int         p;
        bit         acc;
        @(negedge clk);
        reset_n   = rn;
        req_valid = v;
        req_data  = d;
        txready   = tr;
        #1;
        cand = v;
`ifdef UART_ARB_LOCK_EN
        if (m_locked) cand = v & (4'b0001 << m_lock_w);
`endif
        p   = pick(cand, m_last);
        acc = rn && !m_active && tr && (p >= 0);
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), acc ? (32'd1 << p) : 32'd0);
            chk("txclk", 32'(txclk), 32'(m_active && m_age == 1));
            chk("busy", 32'(busy), 32'(m_active));
            chk("grant", 32'(grant), m_active ? (32'd1 << m_w) : 32'd0);
            chk("txdata", 32'(txdata), 32'(m_txdata));
        end
        if (txclk) begin
            slog.push_back(txdata);
            scyc.push_back(cyc);
        end
        last_rdy  = req_ready;
        last_busy = busy;
        last_cyc  = cyc;
        if (!rn) begin
            m_active = 1'b0;
            m_txdata = 8'h00;
            m_last   = NREQ - 1;
            m_locked = 1'b0;
        end else if (acc) begin
            m_active = 1'b1;
            m_age    = 1;
            m_w      = p;
            m_last   = p;
            m_txdata = d[8*p +: 8];
            m_locked = (m_txdata != EOM);
            m_lock_w = p;
        end else if (m_active) begin
            if (m_age >= GUARD + 2 && tr) m_active = 1'b0;
            else m_age++;
        end
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b0, 4'h0, 32'h0, 1'b1);
        step(1'b0, 4'h0, 32'h0, 1'b1);
        slog.delete();
        scyc.delete();
    endtask

    initial begin
        int         ta;
        int         tb;
        int         idx;
        int         nz;
        logic [7:0] b1[3];
        logic [7:0] exp5[5];
        logic [3:0] v;
        logic [31:0] d;

        chk_en   = 1'b0;
        m_active = 1'b0;
        m_last   = NREQ - 1;
        m_locked = 1'b0;
        step(1'b0, 4'h0, 32'h0, 1'b1);
        chk_en = 1'b1;
        do_reset();
        chk("rst_txdata", 32'(txdata), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // single requester: accept, strobe at T+1, busy low at T+GUARD+3
        ta = -1;
        tb = -1;
        for (int n = 0; n < 8; n++) begin
            step(1'b1, 4'b0001, 32'h0000_0041, 1'b1);
            if (ta < 0 && last_rdy == 4'b0001) ta = last_cyc;
            if (ta >= 0 && tb < 0 && !last_busy && last_cyc > ta)
                tb = last_cyc;
        end
        chk("t1_strobe_at", 32'(scyc.size() > 0 ? scyc[0] - ta : -1), 32'd1);
        chk("t1_strobe_data", 32'(slog.size() > 0 ? slog[0] : 8'hFF), 32'h41);
        chk("t1_busy_fall", 32'(tb - ta), 32'(GUARD + 3));

        // all four valid, txready tied high
        do_reset();
        for (int n = 0; n < 24; n++)
            step(1'b1, 4'b1111, 32'h4443_4241, 1'b1);
        chk("t2_count", 32'(slog.size() >= 5), 32'd1);
`ifndef UART_ARB_LOCK_EN
        exp5 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
        for (int i = 0; i < 5 && i < slog.size(); i++)
            chk("t2_order", 32'(slog[i]), 32'(exp5[i]));
        for (int i = 0; i < 4 && i + 1 < scyc.size(); i++)
            chk("t2_period", 32'(scyc[i+1] - scyc[i]), 32'(GUARD + 3));
`endif

        // txready held low through GUARD and 10 WAIT cycles
        do_reset();
        step(1'b1, 4'b0010, 32'h0000_4200, 1'b1);
        for (int n = 0; n < 13; n++)
            step(1'b1, 4'b0000, 32'h0, 1'b0);
        chk("t3_grant", 32'(grant), 32'h2);
        chk("t3_txdata", 32'(txdata), 32'h42);
        chk("t3_strobes", 32'(slog.size()), 32'd1);
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        step(1'b1, 4'b0000, 32'h0, 1'b1);
        chk("t3_idle", 32'(last_busy), 32'd0);

        // reset during STROBE, then requester 0 first
        do_reset();
        step(1'b1, 4'b0100, 32'h0043_0000, 1'b1);
        step(1'b0, 4'b0100, 32'h0043_0000, 1'b1);
        step(1'b1, 4'b1111, 32'h4443_4241, 1'b1);
        chk("t4_txclk", 32'(txclk), 32'd0);
        chk("t4_txdata", 32'(txdata), 32'h0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_first", 32'(last_rdy), 32'h1);

        // message lock: requester 1 sends "hi\n" against requester 2
        do_reset();
        b1  = '{8'h68, 8'h69, 8'h0A};
        idx = 0;
        for (int n = 0; n < 80 && slog.size() < 5; n++) begin
            v = 4'b0100 | ((idx < 3) ? 4'b0010 : 4'b0000);
            d = {8'h00, 8'h5A, ((idx < 3) ? b1[idx] : 8'h00), 8'h00};
            step(1'b1, v, d, 1'b1);
            if (last_rdy[1]) idx++;
        end
`ifdef UART_ARB_LOCK_EN
        exp5 = '{8'h68, 8'h69, 8'h0A, 8'h5A, 8'h5A};
`else
        exp5 = '{8'h68, 8'h5A, 8'h69, 8'h5A, 8'h0A};
`endif
        chk("t5_count", 32'(slog.size()), 32'd5);
        for (int i = 0; i < 5 && i < slog.size(); i++)
            chk("t5_order", 32'(slog[i]), 32'(exp5[i]));

        // txready low in IDLE with every valid pending
        do_reset();
        nz = 0;
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 4'b1111, 32'h4443_4241, 1'b0);
            if (last_rdy != 4'b0000) nz++;
        end
        chk("t6_no_ready", 32'(nz), 32'd0);
        chk("t6_no_strobe", 32'(slog.size()), 32'd0);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            d = $urandom;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) d[8*b +: 8] = EOM;
            step(($urandom_range(0, 99) != 0), 4'($urandom),
                 d, ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
